// File: rtl/gpio_irq_bridge_pkg.sv
// Shared definitions for the GPIO/IRQ bridge: register offsets, decode and byte-lane helpers.
package gpio_irq_bridge_pkg;

   localparam int unsigned WINDOW_BYTES = 256;

   // Byte offsets within the window
   localparam logic [7:0] SW_BASE   = 8'h00;
   localparam logic [7:0] KEY_STATE = 8'h40;
   localparam logic [7:0] KEY_EDGE  = 8'h44;
   localparam logic [7:0] IRQ_EN    = 8'h48;
   localparam logic [7:0] LED       = 8'h50;

   // Idle level of an active-low pin
   localparam logic KEY_RELEASED = 1'b1;

   typedef enum logic [2:0] {
      SEL_NONE,
      SEL_SW,
      SEL_KEY_STATE,
      SEL_KEY_EDGE,
      SEL_IRQ_EN,
      SEL_LED
   } reg_sel_e;

   // Word-aligned offset to register select; SW words occupy 0x00..0x3C
   function automatic reg_sel_e decode_offset(input logic [7:0] offset);
      reg_sel_e sel;
      if (offset[7:6] == SW_BASE[7:6]) begin
         sel = SEL_SW;
      end else begin
         case (offset)
            KEY_STATE: sel = SEL_KEY_STATE;
            KEY_EDGE:  sel = SEL_KEY_EDGE;
            IRQ_EN:    sel = SEL_IRQ_EN;
            LED:       sel = SEL_LED;
            default:   sel = SEL_NONE;
         endcase
      end
      return sel;
   endfunction

   // Expand byte enables to a 32-bit lane mask
   function automatic logic [31:0] byte_mask(input logic [3:0] be);
      logic [31:0] m;
      for (int unsigned i = 0; i < 4; i++) begin
         m[8*i +: 8] = {8{be[i]}};
      end
      return m;
   endfunction

   // Replace only the enabled bytes of old_val with wdata
   function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  be);
      logic [31:0] m;
      m = byte_mask(be);
      return (old_val & ~m) | (wdata & m);
   endfunction

endpackage

// File: rtl/gpio_key_debounce.sv
// One user key: 2-flop synchroniser, stability counter, debounced state and press pulse.
module gpio_key_debounce
   import gpio_irq_bridge_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic key_n,
   output logic key_state,
   output logic key_press
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

   logic [1:0]    sync_q;
   logic          key_seen;
   logic [CW-1:0] cnt_q;
   logic          flip;

   // Bring the raw active-low pin into the clock domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sync_q <= {2{KEY_RELEASED}};
      else        sync_q <= {sync_q[0], key_n};
   end

   assign key_seen  = ~sync_q[1];
   assign flip      = (key_seen != key_state) && (cnt_q == CW'(DEBOUNCE_CYC - 1));
   assign key_press = flip & ~key_state;

   // Count consecutive disagreeing samples; accept the change on the last one
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q     <= '0;
         key_state <= 1'b0;
      end else if (key_seen == key_state) begin
         cnt_q <= '0;
      end else if (flip) begin
         cnt_q     <= '0;
         key_state <= ~key_state;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/gpio_irq_bridge.sv
// Memory-mapped GPIO bridge: DIP-switch banks, debounced keys with sticky press flags
// and maskable interrupt, byte-writable LED register. Pins active-low, registers active-high.
module gpio_irq_bridge
   import gpio_irq_bridge_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_7F00,
   parameter int unsigned N_SW_BYTES   = 8,
   parameter int unsigned N_KEYS       = 8,
   parameter int unsigned LED_W        = 32,
   parameter int unsigned DEBOUNCE_CYC = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [31:0]             addr_in,
   input  logic [31:0]             data_in,
   input  logic [3:0]              byteen,
   output logic [31:0]             data_out,
   input  logic [8*N_SW_BYTES-1:0] dip_switch,
   input  logic [N_KEYS-1:0]       user_key,
   output logic [LED_W-1:0]        led,
   output logic                    irq
);

   localparam int unsigned SW_BITS  = 8 * N_SW_BYTES;
   localparam int unsigned WIN_BITS = $clog2(WINDOW_BYTES);

   logic [SW_BITS-1:0] sw_s1_q, sw_s2_q;
   logic [511:0]       sw_flat;

   logic [N_KEYS-1:0]  key_state, key_press;
   logic [N_KEYS-1:0]  key_edge_q, key_edge_nxt;
   logic [N_KEYS-1:0]  irq_en_q, irq_en_nxt;
   logic [LED_W-1:0]   led_q, led_nxt;

   logic               win_hit, wr_en;
   logic [7:0]         offset;
   reg_sel_e           sel;
   logic [31:0]        wmask, edge_clr32, irq_en_wr32, led_wr32;
   logic               unused_bits;

   assign win_hit = (addr_in[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]);
   assign offset  = {addr_in[7:2], 2'b00};
   assign sel     = win_hit ? decode_offset(offset) : SEL_NONE;
   assign wr_en   = |byteen;

   // Switch synchroniser; switches are only read, never debounced
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_s1_q <= '1;
         sw_s2_q <= '1;
      end else begin
         sw_s1_q <= dip_switch;
         sw_s2_q <= sw_s1_q;
      end
   end

   // Present switches active-high across all 16 word slots; missing bytes read 0
   always_comb begin
      sw_flat              = '0;
      sw_flat[SW_BITS-1:0] = ~sw_s2_q;
   end

   for (genvar i = 0; i < N_KEYS; i++) begin : g_key
      gpio_key_debounce #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_debounce (
         .clk      (clk),
         .reset    (reset),
         .key_n    (user_key[i]),
         .key_state(key_state[i]),
         .key_press(key_press[i])
      );
   end

   // Next-state for writable registers; a new press wins over a same-cycle clear
   always_comb begin
      wmask       = byte_mask(byteen);
      edge_clr32  = '0;
      irq_en_wr32 = 32'(irq_en_q);
      led_wr32    = 32'(led_q);
      if (wr_en && sel == SEL_KEY_EDGE) edge_clr32  = data_in & wmask;
      if (wr_en && sel == SEL_IRQ_EN)   irq_en_wr32 = byte_merge(irq_en_wr32, data_in, byteen);
      if (wr_en && sel == SEL_LED)      led_wr32    = byte_merge(led_wr32, data_in, byteen);
      key_edge_nxt = (key_edge_q & ~edge_clr32[N_KEYS-1:0]) | key_press;
      irq_en_nxt   = irq_en_wr32[N_KEYS-1:0];
      led_nxt      = led_wr32[LED_W-1:0];
   end

   // Register file and interrupt flop; irq follows next-state so it tracks flag/mask without lag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         key_edge_q <= '0;
         irq_en_q   <= '0;
         led_q      <= '0;
         irq        <= 1'b0;
      end else begin
         key_edge_q <= key_edge_nxt;
         irq_en_q   <= irq_en_nxt;
         led_q      <= led_nxt;
         irq        <= |(key_edge_nxt & irq_en_nxt);
      end
   end

   assign led = ~led_q;

   // Combinational read mux
   always_comb begin
      data_out = '0;
      case (sel)
         SEL_SW:        data_out = sw_flat[{addr_in[5:2], 5'b0} +: 32];
         SEL_KEY_STATE: data_out = 32'(key_state);
         SEL_KEY_EDGE:  data_out = 32'(key_edge_q);
         SEL_IRQ_EN:    data_out = 32'(irq_en_q);
         SEL_LED:       data_out = 32'(led_q);
         default:       data_out = '0;
      endcase
   end

   assign unused_bits = ^{addr_in[1:0], edge_clr32, irq_en_wr32, led_wr32};

endmodule

// File: tb/tb_gpio_irq_bridge.sv
// Self-checking bench for gpio_irq_bridge: behavioural model compared every cycle plus
// hand-computed directed expectations.
module tb_gpio_irq_bridge;

   localparam logic [31:0] BASE = 32'h0000_7F00;
   localparam int unsigned NSWB = 8;
   localparam int unsigned NK   = 8;
   localparam int unsigned LW   = 32;
   localparam int unsigned DEB  = 4;
   localparam logic [31:0] DMASK = (32'd1 << DEB) - 32'd1;

   logic                clk = 1'b0;
   logic                reset;
   logic [31:0]         addr_in, data_in, data_out;
   logic [3:0]          byteen;
   logic [8*NSWB-1:0]   dip_switch;
   logic [NK-1:0]       user_key;
   logic [LW-1:0]       led;
   logic                irq;

   int tests = 0;
   int fails = 0;
   logic cmp_on = 1'b0;

   always #5 clk = ~clk;

   gpio_irq_bridge #(
      .BASE_ADDR   (BASE),
      .N_SW_BYTES  (NSWB),
      .N_KEYS      (NK),
      .LED_W       (LW),
      .DEBOUNCE_CYC(DEB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .addr_in   (addr_in),
      .data_in   (data_in),
      .byteen    (byteen),
      .data_out  (data_out),
      .dip_switch(dip_switch),
      .user_key  (user_key),
      .led       (led),
      .irq       (irq)
   );

   // ---------------- behavioural model ----------------
   logic [NK-1:0]     m_key_h0, m_key_h1, m_state, m_edge, m_en;
   logic [31:0]       m_win [NK];
   logic [8*NSWB-1:0] m_sw_h0, m_sw_h1;
   logic [LW-1:0]     m_led;
   logic              m_irq;

   task automatic model_reset();
      m_key_h0 = '1; m_key_h1 = '1; m_sw_h0 = '1; m_sw_h1 = '1;
      m_state = '0; m_edge = '0; m_en = '0; m_led = '0; m_irq = 1'b0;
      for (int i = 0; i < NK; i++) m_win[i] = '0;
   endtask

   // A key flips once its last DEB synchronised samples all disagree with its state
   task automatic model_step();
      logic [31:0]   wm;
      logic [NK-1:0] pressed_now;
      logic          hit;
      logic [7:0]    ofs;
      hit = (addr_in[31:8] == BASE[31:8]) && (byteen != 4'b0);
      ofs = {addr_in[7:2], 2'b00};
      for (int b = 0; b < 4; b++) wm[8*b +: 8] = byteen[b] ? 8'hFF : 8'h00;
      pressed_now = '0;
      for (int i = 0; i < NK; i++) begin
         m_win[i] = {m_win[i][30:0], ~m_key_h1[i]};
         if (!m_state[i] && ((m_win[i] & DMASK) == DMASK)) begin
            m_state[i] = 1'b1;
            pressed_now[i] = 1'b1;
         end else if (m_state[i] && ((m_win[i] & DMASK) == 32'd0)) begin
            m_state[i] = 1'b0;
         end
      end
      m_key_h1 = m_key_h0; m_key_h0 = user_key;
      m_sw_h1  = m_sw_h0;  m_sw_h0  = dip_switch;
      if (hit && ofs == 8'h44) m_edge = m_edge & ~(data_in[NK-1:0] & wm[NK-1:0]);
      m_edge = m_edge | pressed_now;
      if (hit && ofs == 8'h48) m_en = (m_en & ~wm[NK-1:0]) | (data_in[NK-1:0] & wm[NK-1:0]);
      if (hit && ofs == 8'h50) m_led = (m_led & ~wm[LW-1:0]) | (data_in[LW-1:0] & wm[LW-1:0]);
      m_irq = |(m_edge & m_en);
   endtask

   function automatic logic [31:0] model_read(input logic [31:0] a);
      logic [7:0]  o;
      logic [31:0] r;
      o = {a[7:2], 2'b00};
      r = '0;
      if (a[31:8] != BASE[31:8]) return 32'd0;
      if (o < 8'h40) begin
         for (int b = 0; b < 4; b++) begin
            int bi;
            bi = int'(o[7:2]) * 4 + b;
            if (bi < NSWB) r[8*b +: 8] = ~m_sw_h1[8*bi +: 8];
         end
      end else begin
         case (o)
            8'h40:   r = 32'(m_state);
            8'h44:   r = 32'(m_edge);
            8'h48:   r = 32'(m_en);
            8'h50:   r = 32'(m_led);
            default: r = 32'd0;
         endcase
      end
      return r;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) model_reset();
      else        model_step();
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            check("model_led", led, ~m_led);
            check("model_irq", 32'(irq), 32'(m_irq));
            check("model_rdata", data_out, model_read(addr_in));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
      addr_in = a; data_in = d; byteen = be;
      tick();
      byteen = 4'b0;
   endtask

   task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
      addr_in = a; byteen = 4'b0;
      @(negedge clk);
      check(name, data_out, exp);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset = 1'b0; addr_in = '0; data_in = '0; byteen = '0;
      dip_switch = '1; user_key = '1;
      tick(3);
      cmp_on = 1'b1;

      check("rst_led", led, 32'hFFFF_FFFF);
      check("rst_irq", 32'(irq), 32'd0);
      rd("rst_key_state", BASE + 32'h40, 32'd0);
      rd("rst_key_edge",  BASE + 32'h44, 32'd0);
      rd("rst_irq_en",    BASE + 32'h48, 32'd0);
      rd("rst_led_reg",   BASE + 32'h50, 32'd0);
      tick();
      reset = 1'b1;
      tick(2);

      // switches
      dip_switch[31:0]  = ~32'h1234_5678;
      dip_switch[63:32] = ~32'hCAFE_F00D;
      tick(3);
      rd("sw0", BASE + 32'h00, 32'h1234_5678);
      rd("sw1", BASE + 32'h04, 32'hCAFE_F00D);
      rd("sw2_absent", BASE + 32'h08, 32'd0);

      // short glitch on key0 must not register
      tick();
      user_key[0] = 1'b0;
      tick(3);
      user_key[0] = 1'b1;
      tick(8);
      rd("glitch_state", BASE + 32'h40, 32'd0);

      // IRQ_EN upper bits ignored, then enable key0 only
      wr(BASE + 32'h48, 32'hFFFF_FFFF, 4'hF);
      rd("irq_en_full", BASE + 32'h48, 32'h0000_00FF);
      wr(BASE + 32'h48, 32'h0000_0001, 4'h1);
      rd("irq_en_key0", BASE + 32'h48, 32'h0000_0001);

      // key0 held: state flips on the 6th edge after the pin change
      tick();
      user_key[0] = 1'b0;
      tick(5);
      rd("press_not_yet", BASE + 32'h40, 32'd0);
      tick();
      rd("press_state", BASE + 32'h40, 32'h1);
      rd("press_edge", BASE + 32'h44, 32'h1);
      check("press_irq", 32'(irq), 32'd1);

      // clear bit0 in the same cycle key1's edge sets
      tick();
      user_key[1] = 1'b0;
      tick(5);
      wr(BASE + 32'h44, 32'h1, 4'b0001);
      rd("clr_vs_set_other", BASE + 32'h44, 32'h2);
      check("irq_after_clear", 32'(irq), 32'd0);

      // clear and set on the same key: set wins
      tick();
      user_key[2] = 1'b0;
      tick(5);
      wr(BASE + 32'h44, 32'h4, 4'b0001);
      rd("clr_vs_set_same", BASE + 32'h44, 32'h6);

      // clear through disabled byte lanes does nothing
      wr(BASE + 32'h44, 32'hFFFF_FFFF, 4'b1110);
      rd("clr_masked_lane", BASE + 32'h44, 32'h6);

      // mask controls irq
      wr(BASE + 32'h48, 32'h4, 4'b0001);
      check("irq_unmask", 32'(irq), 32'd1);
      wr(BASE + 32'h48, 32'h0, 4'b0001);
      check("irq_mask", 32'(irq), 32'd0);

      // LED byte writes
      wr(BASE + 32'h50, 32'hAABB_CCDD, 4'hF);
      wr(BASE + 32'h50, 32'h1122_3344, 4'b0101);
      rd("led_reg", BASE + 32'h50, 32'hAA22_CC44);
      check("led_pins", led, 32'h55DD_33BB);

      // unmapped offset and out-of-window writes/reads
      wr(BASE + 32'h4C,  32'hFFFF_FFFF, 4'hF);
      wr(BASE + 32'h100, 32'hFFFF_FFFF, 4'hF);
      wr(BASE + 32'h150, 32'hFFFF_FFFF, 4'hF);
      rd("hole_4c", BASE + 32'h4C, 32'd0);
      rd("outside", BASE + 32'h100, 32'd0);
      rd("led_kept", BASE + 32'h50, 32'hAA22_CC44);
      rd("en_kept", BASE + 32'h48, 32'd0);

      // reset mid-run with keys 0..2 held, then re-qualification
      tick();
      reset = 1'b0;
      tick();
      check("mid_rst_led", led, 32'hFFFF_FFFF);
      check("mid_rst_irq", 32'(irq), 32'd0);
      rd("mid_rst_state", BASE + 32'h40, 32'd0);
      rd("mid_rst_edge",  BASE + 32'h44, 32'd0);
      rd("mid_rst_en",    BASE + 32'h48, 32'd0);
      rd("mid_rst_led_r", BASE + 32'h50, 32'd0);
      tick();
      reset = 1'b1;
      tick(5);
      rd("requal_not_yet", BASE + 32'h40, 32'd0);
      tick();
      rd("requal_state", BASE + 32'h40, 32'h7);
      rd("requal_edge",  BASE + 32'h44, 32'h7);

      // release does not set edges
      wr(BASE + 32'h44, 32'hFF, 4'b0001);
      user_key[0] = 1'b1;
      tick(10);
      rd("release_state", BASE + 32'h40, 32'h6);
      rd("release_edge",  BASE + 32'h44, 32'd0);

      tick(2);
      cmp_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
